// File: rtl/sprite_pkg.sv
// rtl/sprite_pkg.sv - shared constants, bus size codes and FSM states for the sprite host master
package sprite_pkg;

   localparam int         OBJ_BYTES          = 4;
   localparam logic [5:0] CONTROL_ADDR       = 6'd63;
   localparam int         CTRL_BITMAP_WE     = 0;
   localparam int         CTRL_STAGING_READY = 1;

   localparam logic [1:0] SZ_BYTE = 2'b00;
   localparam logic [1:0] SZ_HALF = 2'b01;
   localparam logic [1:0] SZ_WORD = 2'b10;
   localparam logic [1:0] SZ_NONE = 2'b11;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_OBJ_WR,
      ST_CTRL_WR,
      ST_RD_REQ,
      ST_RD_WAIT,
      ST_BMP_EN,
      ST_BMP_WR,
      ST_BMP_DIS
   } state_t;

   function automatic logic [31:0] ctrl_word(input logic staging, input logic bitmap_we);
      ctrl_word                     = '0;
      ctrl_word[CTRL_STAGING_READY] = staging;
      ctrl_word[CTRL_BITMAP_WE]     = bitmap_we;
   endfunction

endpackage

// File: rtl/sprite_host_master_if.sv
// rtl/sprite_host_master_if.sv - sprite unit host RAM port
interface sprite_host_master_if;

   logic [5:0]  bus_address;
   logic [31:0] bus_wdata;
   logic [1:0]  bus_write_n;
   logic [1:0]  bus_read_n;
   logic [31:0] bus_rdata;
   logic        bus_data_ready;

   modport master (
      output bus_address, bus_wdata, bus_write_n, bus_read_n,
      input  bus_rdata, bus_data_ready
   );

   modport slave (
      input  bus_address, bus_wdata, bus_write_n, bus_read_n,
      output bus_rdata, bus_data_ready
   );

endinterface

// File: rtl/sprite_shadow_table.sv
// rtl/sprite_shadow_table.sv - local copy of the object descriptors, one write port, one read port
module sprite_shadow_table #(
   parameter int MAX_SPRITES = 2,
   parameter int IDXW        = 1
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            wr_en,
   input  logic [IDXW-1:0] wr_idx,
   input  logic [31:0]     wr_data,
   input  logic [IDXW-1:0] rd_idx,
   output logic [31:0]     rd_data
);

   logic [31:0] mem [MAX_SPRITES];

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int k = 0; k < MAX_SPRITES; k++) mem[k] <= '0;
      end else if (wr_en) begin
         mem[wr_idx] <= wr_data;
      end
   end

   assign rd_data = mem[rd_idx];

endmodule

// File: rtl/sprite_host_master.sv
// rtl/sprite_host_master.sv - commits the shadow object table and uploads bitmap words over the host RAM port
module sprite_host_master
   import sprite_pkg::*;
#(
   parameter int MAX_SPRITES = 2,
   parameter int TIMEOUT     = 15,
   localparam int IDXW       = (MAX_SPRITES > 1) ? $clog2(MAX_SPRITES) : 1
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  obj_wr_en,
   input  logic [IDXW-1:0]       obj_wr_idx,
   input  logic [31:0]           obj_wr_data,
   input  logic                  bmp_valid,
   output logic                  bmp_ready,
   input  logic [5:0]            bmp_addr,
   input  logic [31:0]           bmp_data,
   input  logic                  user_interrupt,
   sprite_host_master_if.master  bus,
   output logic [7:0]            ctrl_status,
   output logic                  commit_done,
   output logic                  bus_err,
   output logic                  busy
);

   localparam int              CNTW     = $clog2(TIMEOUT + 1);
   localparam logic [IDXW-1:0] LAST_IDX = IDXW'(MAX_SPRITES - 1);
   localparam logic [6:0]      BMP_LO   = 7'(OBJ_BYTES * MAX_SPRITES);

   state_t          state, state_next;
   logic [IDXW-1:0] obj_idx, obj_idx_next, rd_idx;
   logic [CNTW-1:0] tmo_cnt, tmo_cnt_next;
   logic [31:0]     rd_data, shadow_word;
   logic [5:0]      word_addr;
   logic [6:0]      bmp_end;
   logic            irq_pending, bmp_legal, timed_out;

   logic [5:0]  addr_d, addr_q;
   logic [31:0] wdata_d, wdata_q;
   logic [1:0]  write_n_d, write_n_q, read_n_d, read_n_q;
   logic        commit_d, err_d, status_we;
   logic        unused_rdata;

   // The table is read one cycle ahead of the bus, so a same-cycle write is forwarded.
   assign rd_idx      = (state == ST_OBJ_WR) ? obj_idx + 1'b1 : '0;
   assign shadow_word = (obj_wr_en && obj_wr_idx == rd_idx) ? obj_wr_data : rd_data;
   assign word_addr   = 6'(int'(rd_idx) * OBJ_BYTES);

   sprite_shadow_table #(
      .MAX_SPRITES (MAX_SPRITES),
      .IDXW        (IDXW)
   ) u_shadow (
      .clk     (clk),
      .rst_n   (rst_n),
      .wr_en   (obj_wr_en),
      .wr_idx  (obj_wr_idx),
      .wr_data (obj_wr_data),
      .rd_idx  (rd_idx),
      .rd_data (rd_data)
   );

   assign bmp_end   = {1'b0, bmp_addr} + 7'd3;
   assign bmp_legal = ({1'b0, bmp_addr} >= BMP_LO) && (bmp_end < 7'(CONTROL_ADDR));
   assign timed_out = (tmo_cnt == CNTW'(TIMEOUT - 1));
   assign bmp_ready = (state == ST_BMP_WR) && bmp_valid && !irq_pending;
   assign busy      = (state != ST_IDLE);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state   <= ST_IDLE;
         obj_idx <= '0;
         tmo_cnt <= '0;
      end else begin
         state   <= state_next;
         obj_idx <= obj_idx_next;
         tmo_cnt <= tmo_cnt_next;
      end
   end

   always_comb begin
      state_next   = state;
      obj_idx_next = obj_idx;
      tmo_cnt_next = tmo_cnt;
      case (state)
         ST_IDLE: begin
            if (irq_pending) begin
               state_next   = ST_OBJ_WR;
               obj_idx_next = '0;
            end else if (bmp_valid) begin
               state_next = ST_BMP_EN;
            end
         end
         ST_OBJ_WR: begin
            if (obj_idx == LAST_IDX) state_next = ST_CTRL_WR;
            else                     obj_idx_next = obj_idx + 1'b1;
         end
         ST_CTRL_WR: state_next = ST_RD_REQ;
         ST_RD_REQ: begin
            state_next   = ST_RD_WAIT;
            tmo_cnt_next = CNTW'(1);
         end
         ST_RD_WAIT: begin
            if (bus.bus_data_ready || timed_out) state_next = ST_IDLE;
            else                                 tmo_cnt_next = tmo_cnt + 1'b1;
         end
         ST_BMP_EN: state_next = ST_BMP_WR;
         ST_BMP_WR: begin
            if (irq_pending || !bmp_valid) state_next = ST_BMP_DIS;
         end
         ST_BMP_DIS: state_next = ST_IDLE;
         default:    state_next = ST_IDLE;
      endcase
   end

   // Each value computed here is what the bus shows while in the following state.
   always_comb begin
      addr_d    = '0;
      wdata_d   = '0;
      write_n_d = SZ_NONE;
      read_n_d  = SZ_NONE;
      commit_d  = 1'b0;
      err_d     = 1'b0;
      status_we = 1'b0;
      case (state)
         ST_IDLE: begin
            if (irq_pending) begin
               write_n_d = SZ_WORD;
               addr_d    = word_addr;
               wdata_d   = shadow_word;
            end else if (bmp_valid) begin
               write_n_d = SZ_BYTE;
               addr_d    = CONTROL_ADDR;
               wdata_d   = ctrl_word(1'b0, 1'b1);
            end
         end
         ST_OBJ_WR: begin
            if (obj_idx == LAST_IDX) begin
               write_n_d = SZ_BYTE;
               addr_d    = CONTROL_ADDR;
               wdata_d   = ctrl_word(1'b1, 1'b0);
            end else begin
               write_n_d = SZ_WORD;
               addr_d    = word_addr;
               wdata_d   = shadow_word;
            end
         end
         ST_CTRL_WR: begin
            read_n_d = SZ_BYTE;
            addr_d   = CONTROL_ADDR;
         end
         ST_RD_WAIT: begin
            if (bus.bus_data_ready) begin
               commit_d  = 1'b1;
               status_we = 1'b1;
            end else if (timed_out) begin
               err_d = 1'b1;
            end
         end
         ST_BMP_WR: begin
            if (irq_pending || !bmp_valid) begin
               write_n_d = SZ_BYTE;
               addr_d    = CONTROL_ADDR;
               wdata_d   = ctrl_word(1'b0, 1'b0);
            end else if (bmp_legal) begin
               write_n_d = SZ_WORD;
               addr_d    = bmp_addr;
               wdata_d   = bmp_data;
            end else begin
               err_d = 1'b1;
            end
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr_q      <= '0;
         wdata_q     <= '0;
         write_n_q   <= SZ_NONE;
         read_n_q    <= SZ_NONE;
         commit_done <= 1'b0;
         bus_err     <= 1'b0;
         ctrl_status <= '0;
         irq_pending <= 1'b0;
      end else begin
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         write_n_q   <= write_n_d;
         read_n_q    <= read_n_d;
         commit_done <= commit_d;
         bus_err     <= err_d;
         if (status_we) ctrl_status <= bus.bus_rdata[7:0];
         // A new interrupt wins over the clear, so a request during a commit is not lost.
         irq_pending <= user_interrupt || (irq_pending && state != ST_IDLE);
      end
   end

   assign bus.bus_address = addr_q;
   assign bus.bus_wdata   = wdata_q;
   assign bus.bus_write_n = write_n_q;
   assign bus.bus_read_n  = read_n_q;
   assign unused_rdata    = ^bus.bus_rdata[31:8];

endmodule

// File: tb/tb_sprite_host_master.sv
// tb/tb_sprite_host_master.sv - directed bench for sprite_host_master
module tb_sprite_host_master;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        obj_wr_en;
   logic [0:0]  obj_wr_idx;
   logic [31:0] obj_wr_data;
   logic        bmp_valid;
   logic        bmp_ready;
   logic [5:0]  bmp_addr;
   logic [31:0] bmp_data;
   logic        user_interrupt;
   logic [7:0]  ctrl_status;
   logic        commit_done;
   logic        bus_err;
   logic        busy;
   int          checks = 0;
   int          errors = 0;

   sprite_host_master_if bus_if ();

   sprite_host_master #(.MAX_SPRITES(2), .TIMEOUT(15)) dut (
      .clk            (clk),
      .rst_n          (rst_n),
      .obj_wr_en      (obj_wr_en),
      .obj_wr_idx     (obj_wr_idx),
      .obj_wr_data    (obj_wr_data),
      .bmp_valid      (bmp_valid),
      .bmp_ready      (bmp_ready),
      .bmp_addr       (bmp_addr),
      .bmp_data       (bmp_data),
      .user_interrupt (user_interrupt),
      .bus            (bus_if),
      .ctrl_status    (ctrl_status),
      .commit_done    (commit_done),
      .bus_err        (bus_err),
      .busy           (busy)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic chk_word(input string tag, input logic [5:0] a, input logic [31:0] d);
      chk({tag, ".write_n"}, 32'(bus_if.bus_write_n), 32'h2);
      chk({tag, ".read_n"},  32'(bus_if.bus_read_n),  32'h3);
      chk({tag, ".addr"},    32'(bus_if.bus_address), 32'(a));
      chk({tag, ".wdata"},   bus_if.bus_wdata,        d);
   endtask

   task automatic chk_byte(input string tag, input logic [5:0] a, input logic [7:0] d);
      chk({tag, ".write_n"}, 32'(bus_if.bus_write_n), 32'h0);
      chk({tag, ".read_n"},  32'(bus_if.bus_read_n),  32'h3);
      chk({tag, ".addr"},    32'(bus_if.bus_address), 32'(a));
      chk({tag, ".wdata"},   bus_if.bus_wdata,        32'(d));
   endtask

   task automatic chk_read(input string tag);
      chk({tag, ".write_n"}, 32'(bus_if.bus_write_n), 32'h3);
      chk({tag, ".read_n"},  32'(bus_if.bus_read_n),  32'h0);
      chk({tag, ".addr"},    32'(bus_if.bus_address), 32'd63);
   endtask

   task automatic chk_idle(input string tag);
      chk({tag, ".write_n"}, 32'(bus_if.bus_write_n), 32'h3);
      chk({tag, ".read_n"},  32'(bus_if.bus_read_n),  32'h3);
   endtask

   initial begin
      rst_n = 1'b0;
      obj_wr_en = 1'b0; obj_wr_idx = '0; obj_wr_data = '0;
      bmp_valid = 1'b0; bmp_addr = '0; bmp_data = '0;
      user_interrupt = 1'b0;
      bus_if.bus_rdata = '0; bus_if.bus_data_ready = 1'b0;

      // reset values
      step();
      chk_idle("rst");
      chk("rst.addr", 32'(bus_if.bus_address), 32'd0);
      chk("rst.wdata", bus_if.bus_wdata, 32'd0);
      chk("rst.status", 32'(ctrl_status), 32'd0);
      chk("rst.pulses", {28'd0, commit_done, bus_err, bmp_ready, busy}, 32'd0);
      rst_n = 1'b1;
      step();

      // commit of a loaded shadow table
      obj_wr_en = 1'b1; obj_wr_idx = 1'b0; obj_wr_data = 32'h1F00_2010;
      step();
      obj_wr_idx = 1'b1; obj_wr_data = 32'h3320_4030;
      step();
      obj_wr_en = 1'b0; user_interrupt = 1'b1;
      step();
      user_interrupt = 1'b0;
      chk("c1.idle_busy", 32'(busy), 32'd0);
      step(); chk_word("c1.w0", 6'd0, 32'h1F00_2010);
      chk("c1.busy", 32'(busy), 32'd1);
      step(); chk_word("c1.w1", 6'd4, 32'h3320_4030);
      step(); chk_byte("c1.ctrl", 6'd63, 8'h02);
      step(); chk_read("c1.rd");
      step(); chk_idle("c1.wait");
      step();
      chk("c1.done_early", 32'(commit_done), 32'd0);
      bus_if.bus_rdata = 32'h0000_0002; bus_if.bus_data_ready = 1'b1;
      step();
      chk("c1.done", 32'(commit_done), 32'd1);
      chk("c1.status", 32'(ctrl_status), 32'h02);
      chk("c1.busy_end", 32'(busy), 32'd0);
      bus_if.bus_data_ready = 1'b0;
      step();
      chk("c1.done_pulse", 32'(commit_done), 32'd0);

      // bitmap burst at 8, 12, 16
      bmp_valid = 1'b1; bmp_addr = 6'd8; bmp_data = 32'hA0A0_0008;
      step(); chk_byte("b1.en", 6'd63, 8'h01);
      chk("b1.en_ready", 32'(bmp_ready), 32'd0);
      step(); chk_idle("b1.first");
      chk("b1.ready0", 32'(bmp_ready), 32'd1);
      step(); chk_word("b1.w8", 6'd8, 32'hA0A0_0008);
      bmp_addr = 6'd12; bmp_data = 32'hB0B0_000C;
      step(); chk_word("b1.w12", 6'd12, 32'hB0B0_000C);
      bmp_addr = 6'd16; bmp_data = 32'hC0C0_0010;
      step(); chk_word("b1.w16", 6'd16, 32'hC0C0_0010);
      bmp_valid = 1'b0;
      step(); chk_byte("b1.dis", 6'd63, 8'h00);
      chk("b1.dis_ready", 32'(bmp_ready), 32'd0);
      step(); chk_idle("b1.idle");
      chk("b1.busy", 32'(busy), 32'd0);

      // illegal addresses 60 and 4, then the legal edge 59
      bmp_valid = 1'b1; bmp_addr = 6'd60; bmp_data = 32'hDEAD_003C;
      step(); chk_byte("b2.en", 6'd63, 8'h01);
      step(); chk("b2.ready", 32'(bmp_ready), 32'd1);
      step(); chk_idle("b2.no60");
      chk("b2.err60", 32'(bus_err), 32'd1);
      chk("b2.ready4", 32'(bmp_ready), 32'd1);
      bmp_addr = 6'd4; bmp_data = 32'hDEAD_0004;
      step(); chk_idle("b2.no4");
      chk("b2.err4", 32'(bus_err), 32'd1);
      bmp_addr = 6'd59; bmp_data = 32'hF0F0_003B;
      step(); chk_word("b2.w59", 6'd59, 32'hF0F0_003B);
      chk("b2.err59", 32'(bus_err), 32'd0);
      bmp_valid = 1'b0;
      step(); chk_byte("b2.dis", 6'd63, 8'h00);
      step(); chk_idle("b2.idle");

      // interrupt during a burst with bmp_valid held high
      bmp_valid = 1'b1; bmp_addr = 6'd20; bmp_data = 32'hE0E0_0014;
      step(); chk_byte("b3.en", 6'd63, 8'h01);
      step(); chk("b3.ready", 32'(bmp_ready), 32'd1);
      user_interrupt = 1'b1;
      step(); chk_word("b3.w20", 6'd20, 32'hE0E0_0014);
      chk("b3.ready_blocked", 32'(bmp_ready), 32'd0);
      user_interrupt = 1'b0;
      step(); chk_byte("b3.dis", 6'd63, 8'h00);
      step(); chk_idle("b3.idle");
      chk("b3.idle_busy", 32'(busy), 32'd0);
      bmp_valid = 1'b0;
      step(); chk_word("c2.w0", 6'd0, 32'h1F00_2010);
      step(); chk_word("c2.w1", 6'd4, 32'h3320_4030);
      user_interrupt = 1'b1;
      step(); chk_byte("c2.ctrl", 6'd63, 8'h02);
      user_interrupt = 1'b0;
      step(); chk_read("c2.rd");
      step(); chk_idle("c2.wait");
      step();
      bus_if.bus_rdata = 32'hABCD_EF82; bus_if.bus_data_ready = 1'b1;
      step();
      chk("c2.done", 32'(commit_done), 32'd1);
      chk("c2.status", 32'(ctrl_status), 32'h82);
      bus_if.bus_data_ready = 1'b0;

      // re-armed commit whose read never returns
      step(); chk_word("c3.w0", 6'd0, 32'h1F00_2010);
      step(); chk_word("c3.w1", 6'd4, 32'h3320_4030);
      step(); chk_byte("c3.ctrl", 6'd63, 8'h02);
      step(); chk_read("c3.rd");
      for (int k = 1; k < 15; k++) step();
      chk("c3.err_early", 32'(bus_err), 32'd0);
      chk("c3.busy_wait", 32'(busy), 32'd1);
      step();
      chk("c3.err", 32'(bus_err), 32'd1);
      chk("c3.busy_end", 32'(busy), 32'd0);
      chk("c3.status_kept", 32'(ctrl_status), 32'h82);
      chk("c3.no_done", 32'(commit_done), 32'd0);
      step();
      chk("c3.err_pulse", 32'(bus_err), 32'd0);

      // asynchronous reset in the middle of OBJ_WR
      user_interrupt = 1'b1;
      step();
      user_interrupt = 1'b0;
      step(); chk_word("r.w0", 6'd0, 32'h1F00_2010);
      #2 rst_n = 1'b0;
      #1;
      chk_idle("r.async");
      chk("r.addr", 32'(bus_if.bus_address), 32'd0);
      chk("r.wdata", bus_if.bus_wdata, 32'd0);
      chk("r.busy", 32'(busy), 32'd0);
      chk("r.status", 32'(ctrl_status), 32'd0);
      step();
      rst_n = 1'b1;
      step(); step();
      chk_idle("r.after");
      chk("r.after_busy", 32'(busy), 32'd0);
      user_interrupt = 1'b1;
      step();
      user_interrupt = 1'b0;
      step(); chk_word("r.w0_clr", 6'd0, 32'h0);
      step(); chk_word("r.w1_clr", 6'd4, 32'h0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/sprite_host_master.md
Name: sprite_host_master

Overview:
Bus initiator that drives the sprite unit's host RAM port (byte address, 32-bit data, write_n/read_n size codes, data_ready).
- Keeps a local shadow object table of MAX_SPRITES 32-bit descriptors and services the sprite unit's user_interrupt. On each request it writes the shadow table into the staging object area, sets STAGING_READY, then reads the control byte back to confirm.
- Also serialises bitmap word uploads, bracketing them with BITMAP_WRITE_EN set and clear.

Parameters:
MAX_SPRITES, 2, descriptor count; must match the sprite unit. Object area is bytes 0..4*MAX_SPRITES-1.
TIMEOUT, 15, maximum cycles to wait for bus_data_ready after a read request.

Ports:
clk  in  1  system clock
rst_n  in  1  reset; asynchronous, active-low
obj_wr_en  in  1  write one shadow descriptor
obj_wr_idx  in  $clog2(MAX_SPRITES) (min 1)  descriptor index
obj_wr_data  in  32  {size,bitmap_off,y,x}; byte0 = x
bmp_valid  in  1  bitmap upload request
bmp_ready  out  1  request accepted this cycle
bmp_addr  in  6  absolute byte address of the bitmap word
bmp_data  in  32  bitmap word, byte0 at bmp_addr
user_interrupt  in  1  1-cycle request pulse from the sprite unit
bus_address  out  6  byte address
bus_wdata  out  32  write data
bus_write_n  out  2  00 byte, 10 word, 11 idle
bus_read_n  out  2  00 byte, 11 idle
bus_rdata  in  32  read data
bus_data_ready  in  1  read data valid
ctrl_status  out  8  last control byte read back
commit_done  out  1  1-cycle pulse when a commit is confirmed
bus_err  out  1  1-cycle pulse on timeout or bad bitmap address
busy  out  1  FSM not in IDLE

Behaviour:
- Reset (async, rst_n low): FSM=IDLE; bus_write_n=bus_read_n=11; bus_address=0; bus_wdata=0; ctrl_status=0; commit_done=bus_err=bmp_ready=busy=0; irq_pending=0; shadow table cleared; timeout counter 0.
  - Reset mid-transaction abandons the transaction immediately. No cleanup writes are issued.
- Bus outputs are registered. At most one transaction per cycle. Every non-transaction cycle drives 11/11.
- irq_pending is set by user_interrupt in any state. It is cleared on entering OBJ_WR.
- Shadow writes (obj_wr_en) are accepted in every state and take effect next cycle.
  - During OBJ_WR, a word that has already been sent keeps its old value.
- FSM states:
  - IDLE:
    - If irq_pending, go to OBJ_WR with i=0. This has priority.
    - Else if bmp_valid, go to BMP_EN.
  - OBJ_WR:
    - Word write: address 4*i, data shadow[i], write_n=10.
    - i increments; after i=MAX_SPRITES-1, go to CTRL_WR.
  - CTRL_WR: byte write of 0x02 to address 63, then RD_REQ.
  - RD_REQ: byte read (read_n=00) of address 63 for one cycle; clear timeout counter; go to RD_WAIT.
  - RD_WAIT:
    - On bus_data_ready: ctrl_status<=bus_rdata[7:0]; pulse commit_done; go to IDLE.
    - If the counter reaches TIMEOUT first: pulse bus_err; go to IDLE.
    - The sprite unit returns data 2 cycles after the request cycle.
  - BMP_EN:
    - Byte write of 0x01 to address 63, then BMP_WR.
    - bmp_ready is not asserted in this state.
  - BMP_WR:
    - If bmp_valid, assert bmp_ready (combinational from state and valid) in the same cycle.
      - If bmp_addr is word-legal (bmp_addr >= 4*MAX_SPRITES and bmp_addr+3 <= 62), issue a word write of bmp_data.
      - Otherwise issue no write and pulse bus_err.
      - Either way, stay in BMP_WR.
    - If bmp_valid is low, or irq_pending is set, go to BMP_DIS. irq_pending is checked before accepting.
  - BMP_DIS: byte write of 0x00 to address 63, then IDLE.
- STAGING_READY and BITMAP_WRITE_EN are never set together. Control is only written with byte writes.
- Commit latency is MAX_SPRITES+4 cycles from IDLE to commit_done (MAX_SPRITES=2: 6 cycles).
- A user_interrupt arriving during a commit re-arms irq_pending, so a second commit follows.

Decomposition:
- Shared package sprite_pkg holds:
  - OBJ_BYTES=4, CONTROL_ADDR=63, CTRL_BITMAP_WE=bit0, CTRL_STAGING_READY=bit1.
  - Size codes SZ_BYTE=00, SZ_HALF=01, SZ_WORD=10, SZ_NONE=11.
  - FSM state enum.
- One natural sub-module: sprite_shadow_table (MAX_SPRITES x 32 register file, one write port, one indexed read port).

Test Plan:
- Reset, then load shadow[0]=0x1F00_2010 and shadow[1]=0x3320_4030; pulse user_interrupt.
  - Bus shows word writes to 0 then 4 with those values, then a byte write of 0x02 to 63, then a byte read of 63.
  - With the responder returning 0x02: commit_done is high 6 cycles after leaving IDLE and ctrl_status=0x02.
- bmp_valid for 3 words at addresses 8, 12, 16.
  - Bus shows byte 0x01 @63, word writes @8, @12, @16 with one bmp_ready each, then byte 0x00 @63.
- bmp_addr=60 (60+3 > 62) or bmp_addr=4 (inside the object area, MAX_SPRITES=2).
  - bmp_ready=1, bus_err pulses, no word write is issued, and the sequence still closes with 0x00 @63.
- user_interrupt during a bitmap burst with bmp_valid held high.
  - The burst stops, 0x00 @63 is written, then the commit sequence runs. No 0x03 is ever written.
- Responder never raises data_ready.
  - bus_err pulses TIMEOUT cycles after RD_REQ; FSM returns to IDLE; ctrl_status is unchanged.
- rst_n asserted low mid-OBJ_WR.
  - Bus goes to 11/11 asynchronously and all outputs take their reset values. After release, FSM is IDLE and irq_pending=0.
